fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch front end and upstream feeder of decode.
//  Holds the PC and issues one 32-bit fetch at a time on the instruction bus.
//  Presents each fetched instruction with its PC to decode via a valid/ready handshake.
//  Consumes the jump_writer redirect from execute and squashes wrong-path fetches,
//  including a fetch that is already in flight.
// PARAMETERS
//  RESET_PC  64'h8000_0000  PC of the first fetch after reset
// PORTS
//  Reset is asynchronous and active-low.
//  clk             in   1    clock
//  rst_n           in   1    reset, asynchronous, active-low
//  jmp             in   jump_writer  redirect; only do_jump and dest_addr are used
//  imem_req_valid  out  1    fetch request
//  imem_req_addr   out  64   fetch address, word aligned
//  imem_resp_valid in   1    data_ok; completes the current request
//  imem_resp_data  in   32   instruction word
//  if_valid        out  1    instruction available to decode
//  if_ready        in   1    decode accepts (transfer = if_valid & if_ready)
//  if_pc           out  64   PC of if_inst
//  if_inst         out  32   instruction
//  fetch_cnt       out  64   accepted transfers to decode
//  squash_cnt      out  64   discarded responses plus squashed held instructions
// BEHAVIOUR
//  Reset values
//   - state=REQ, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC.
//   - if_valid=0, if_pc=RESET_PC, if_inst=0, both counters=0, no pending target.
//   - An assertion of rst_n low mid-operation forces these values immediately.
//   - Any in-flight response arriving after reset is ignored.
//  Bus rule: once imem_req_valid=1, the request is never retracted and
//   imem_req_addr stays stable until the cycle imem_resp_valid=1.
//  Redirect target: jmp.dest_addr with bits [1:0] forced to 0.
//  Redirect priority: jmp.do_jump beats every other event in the same cycle.
//  States and transitions
//   - REQ: imem_req_valid=1, addr=pc; imem_req_valid rises on the 1st cycle after rst_n=1.
//       resp & !do_jump : latch inst/pc, pc<=pc+4, ->HOLD (if_valid=1 next cycle).
//       resp &  do_jump : discard, squash_cnt++, pc<=target, stay REQ;
//                         new address is driven next cycle.
//      !resp &  do_jump : pending<=target, ->FLUSH.
//   - FLUSH: imem_req_valid=1, old addr held.
//       Further do_jump overwrites pending (latest wins).
//       On resp: discard, squash_cnt++, pc<=(do_jump ? target : pending), ->REQ.
//   - HOLD: imem_req_valid=0 (no prefetch). if_valid = held & ~jmp.do_jump (combinational).
//       do_jump          : squash held inst, squash_cnt++, pc<=target, ->REQ.
//       if_ready & !jump : fetch_cnt++, ->REQ; next fetch issued the following cycle.
//       !if_ready        : if_pc/if_inst held stable.
//  Timing and arithmetic
//   - Best-case throughput: one instruction per 3 cycles with a 1-cycle memory.
//   - pc+4 and both counters wrap modulo 2^64 with no flag.
// TESTING
//  1. Reset release; memory returns 32'h0000_0013 1 cycle later
//     -> req addr 8000_0000; if_valid with if_pc 8000_0000, if_inst 13;
//        after accept, next req addr 8000_0004.
//  2. HOLD with if_ready=0 for 5 cycles
//     -> if_valid/if_pc/if_inst stable, imem_req_valid=0, fetch_cnt unchanged.
//  3. Req 8000_0008 outstanding, do_jump dest 8000_1000, resp 3 cycles later
//     -> addr held at 8000_0008 until resp; resp discarded;
//        next req 8000_1000; squash_cnt=1.
//  4. do_jump dest 8000_2002 in the same cycle as resp
//     -> no if_valid; next req 8000_2000; squash_cnt+1.
//  5. HOLD with if_ready=1 and do_jump dest 8000_3000 in the same cycle
//     -> if_valid=0 that cycle; fetch_cnt unchanged; next req 8000_3000.
//  6. rst_n low while in FLUSH, late resp arrives afterwards
//     -> outputs at reset values immediately; late resp ignored;
//        first req after release is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: single outstanding 32-bit fetch, valid/ready hand-off to decode,
// and redirect handling that squashes wrong-path fetches, including one already in flight.
package fetch_pkg;
    typedef struct packed {
        logic        do_jump;
        logic [63:0] dest_addr;
    } jump_writer;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  jump_writer  jmp,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    output logic [63:0] fetch_cnt,
    output logic [63:0] squash_cnt
);

    // Decode handshake: a transfer happens on a cycle where if_valid & if_ready;
    // if_pc/if_inst stay stable while if_valid is high and if_ready is low.
    typedef enum logic [1:0] {REQ, FLUSH, HOLD} state_t;

    state_t      state, state_next;
    logic        active;
    logic [63:0] pc, pc_next;
    logic [63:0] pending, pending_next;
    logic [63:0] target;
    logic        resp;
    logic        latch_inst;
    logic        fetch_inc;
    logic        squash_inc;

    // The request only goes out once the first clock after reset release has passed,
    // so a response from a pre-reset request can never be mistaken for a new one.
    assign target         = jmp.dest_addr & ~64'h3;
    assign resp           = imem_resp_valid & active;
    assign imem_req_valid = active & (state != HOLD);
    assign imem_req_addr  = pc;
    assign if_valid       = (state == HOLD) & ~jmp.do_jump;

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pending_next = pending;
        latch_inst   = 1'b0;
        fetch_inc    = 1'b0;
        squash_inc   = 1'b0;
        case (state)
            REQ: begin
                if (resp && jmp.do_jump) begin
                    squash_inc = 1'b1;
                    pc_next    = target;
                end else if (resp) begin
                    latch_inst = 1'b1;
                    pc_next    = pc + 64'd4;
                    state_next = HOLD;
                end else if (active && jmp.do_jump) begin
                    pending_next = target;
                    state_next   = FLUSH;
                end
            end
            FLUSH: begin
                // The request address must stay put until memory answers; the latest redirect wins.
                if (jmp.do_jump) pending_next = target;
                if (resp) begin
                    squash_inc = 1'b1;
                    pc_next    = jmp.do_jump ? target : pending;
                    state_next = REQ;
                end
            end
            HOLD: begin
                if (jmp.do_jump) begin
                    squash_inc = 1'b1;
                    pc_next    = target;
                    state_next = REQ;
                end else if (if_ready) begin
                    fetch_inc  = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REQ;
            active     <= 1'b0;
            pc         <= RESET_PC;
            pending    <= RESET_PC;
            if_pc      <= RESET_PC;
            if_inst    <= 32'd0;
            fetch_cnt  <= 64'd0;
            squash_cnt <= 64'd0;
        end else begin
            state   <= state_next;
            active  <= 1'b1;
            pc      <= pc_next;
            pending <= pending_next;
            if (latch_inst) begin
                if_pc   <= pc;
                if_inst <= imem_resp_data;
            end
            if (fetch_inc)  fetch_cnt  <= fetch_cnt + 64'd1;
            if (squash_inc) squash_cnt <= squash_cnt + 64'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, decode stall, redirects in REQ/FLUSH/HOLD and reset mid-flush.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    jump_writer  jmp;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic [63:0] fetch_cnt;
    logic [63:0] squash_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(64'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .jmp(jmp),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; jmp = '0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0; if_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 64'h8000_0000) begin n_err++; $display("FAIL rst_req_addr: got %h want 80000000", imem_req_addr); end
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_pc !== 64'h8000_0000) begin n_err++; $display("FAIL rst_if_pc: got %h want 80000000", if_pc); end
        n_cmp++; if (if_inst !== 32'd0) begin n_err++; $display("FAIL rst_if_inst: got %h want 0", if_inst); end
        n_cmp++; if (fetch_cnt !== 64'd0 || squash_cnt !== 64'd0) begin n_err++; $display("FAIL rst_counters: got %0d/%0d want 0/0", fetch_cnt, squash_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin n_err++; $display("FAIL first_req: got %b %h want 1 80000000", imem_req_valid, imem_req_addr); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0000 || if_inst !== 32'h13) begin n_err++; $display("FAIL first_inst: got %b %h %h want 1 80000000 00000013", if_valid, if_pc, if_inst); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL hold_no_prefetch: got %b want 0", imem_req_valid); end
    endtask

    task automatic test_hold_stall();
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 64'h8000_0000 || if_inst !== 32'h13 || imem_req_valid !== 1'b0 || fetch_cnt !== 64'd0) begin
                n_err++; $display("FAIL stall_cycle%0d: got v=%b pc=%h inst=%h req=%b fc=%0d want 1 80000000 00000013 0 0", i, if_valid, if_pc, if_inst, imem_req_valid, fetch_cnt);
            end
        end
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        n_cmp++; if (fetch_cnt !== 64'd1) begin n_err++; $display("FAIL accept_cnt: got %0d want 1", fetch_cnt); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004 || if_valid !== 1'b0) begin n_err++; $display("FAIL next_req: got %b %h v=%b want 1 80000004 v=0", imem_req_valid, imem_req_addr, if_valid); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0004 || if_inst !== 32'h0010_0093) begin n_err++; $display("FAIL second_inst: got %b %h %h want 1 80000004 00100093", if_valid, if_pc, if_inst); end
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        n_cmp++; if (fetch_cnt !== 64'd2 || imem_req_addr !== 64'h8000_0008) begin n_err++; $display("FAIL third_req: got fc=%0d %h want 2 80000008", fetch_cnt, imem_req_addr); end
    endtask

    task automatic test_jump_in_flight();
        jmp.do_jump = 1'b1; jmp.dest_addr = 64'h8000_0f00;
        @(negedge clk);
        jmp.dest_addr = 64'h8000_1000;
        @(negedge clk);
        jmp = '0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008) begin n_err++; $display("FAIL flush_addr_held0: got %b %h want 1 80000008", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008 || if_valid !== 1'b0) begin n_err++; $display("FAIL flush_addr_held1: got %b %h v=%b want 1 80000008 v=0", imem_req_valid, imem_req_addr, if_valid); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin n_err++; $display("FAIL flush_redirect: got v=%b %b %h want v=0 1 80001000", if_valid, imem_req_valid, imem_req_addr); end
        n_cmp++; if (squash_cnt !== 64'd1) begin n_err++; $display("FAIL flush_squash: got %0d want 1", squash_cnt); end
    endtask

    task automatic test_jump_with_resp();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
        jmp.do_jump = 1'b1; jmp.dest_addr = 64'h8000_2002;
        @(negedge clk);
        imem_resp_valid = 1'b0; jmp = '0;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL resp_jump_no_valid: got %b want 0", if_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin n_err++; $display("FAIL resp_jump_addr: got %b %h want 1 80002000", imem_req_valid, imem_req_addr); end
        n_cmp++; if (squash_cnt !== 64'd2) begin n_err++; $display("FAIL resp_jump_squash: got %0d want 2", squash_cnt); end
    endtask

    task automatic test_jump_in_hold();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_2000 || if_inst !== 32'h2222_2222) begin n_err++; $display("FAIL hold_inst: got %b %h %h want 1 80002000 22222222", if_valid, if_pc, if_inst); end
        if_ready = 1'b1; jmp.do_jump = 1'b1; jmp.dest_addr = 64'h8000_3000;
        #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL hold_jump_valid: got %b want 0", if_valid); end
        @(negedge clk);
        if_ready = 1'b0; jmp = '0;
        n_cmp++; if (fetch_cnt !== 64'd2 || squash_cnt !== 64'd3) begin n_err++; $display("FAIL hold_jump_cnts: got %0d/%0d want 2/3", fetch_cnt, squash_cnt); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_3000) begin n_err++; $display("FAIL hold_jump_addr: got %b %h want 1 80003000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_in_flush();
        jmp.do_jump = 1'b1; jmp.dest_addr = 64'h8000_4000;
        @(negedge clk);
        jmp = '0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h8000_0000 || if_valid !== 1'b0 || squash_cnt !== 64'd0 || fetch_cnt !== 64'd0) begin
            n_err++; $display("FAIL async_reset: got req=%b %h v=%b sc=%0d fc=%0d want 0 80000000 0 0 0", imem_req_valid, imem_req_addr, if_valid, squash_cnt, fetch_cnt);
        end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_3333;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000 || if_valid !== 1'b0 || squash_cnt !== 64'd0) begin
            n_err++; $display("FAIL late_resp_ignored: got req=%b %h v=%b sc=%0d want 1 80000000 0 0", imem_req_valid, imem_req_addr, if_valid, squash_cnt);
        end
        @(negedge clk);
        n_cmp++; if (if_valid !== 1'b0 || if_inst !== 32'd0 || imem_req_addr !== 64'h8000_0000) begin n_err++; $display("FAIL post_reset_idle: got v=%b %h %h want 0 00000000 80000000", if_valid, if_inst, imem_req_addr); end
    endtask

    initial begin
        test_reset();
        test_hold_stall();
        test_jump_in_flight();
        test_jump_with_resp();
        test_jump_in_hold();
        test_reset_in_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
